// File: rtl/aspect_supervisor_if.sv
// Cab-signal bus between the aspect receiver / driver desk and the supervisor.
// The master drives the aspects and the acknowledge, and the supervisor returns the enforcement outputs.
interface aspect_supervisor_if;
  logic [1:0] aspect;
  logic       aspect_stb;
  logic       ack;
  logic [7:0] speed_lim;
  logic       brake;
  logic       alarm;
  logic       spad;
  logic [1:0] cur_aspect;

  modport master (
    output aspect, aspect_stb, ack,
    input  speed_lim, brake, alarm, spad, cur_aspect
  );

  modport slave (
    input  aspect, aspect_stb, ack,
    output speed_lim, brake, alarm, spad, cur_aspect
  );
endinterface

// File: rtl/aspect_supervisor.sv
// On-board aspect supervisor: enforces trackside aspects with speed limits,
// driver-ack supervision for restrictive aspects, and an absorbing SPAD trip.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_HOLD  | after reset, no aspect seen yet; brake applied
// S_RUN   | proceeding under green or acknowledged restrictive aspect
// S_WARN  | restrictive aspect awaiting driver ack; cnt counts the wait
// S_BRAKE | ack was late; brake held until a green (or red) strobe
// S_TRIP  | red passed; everything frozen until reset
module aspect_supervisor #(
  parameter int unsigned ACK_TIMEOUT = 20,
  parameter logic [7:0]  SPD_G       = 8'd120,
  parameter logic [7:0]  SPD_Y       = 8'd80,
  parameter logic [7:0]  SPD_YY      = 8'd40
) (
  input logic                clk,
  input logic                clr_n,
  aspect_supervisor_if.slave bus
);

  typedef enum logic [2:0] {
    S_HOLD,
    S_RUN,
    S_WARN,
    S_BRAKE,
    S_TRIP
  } state_t;

  localparam logic [1:0] ASP_R  = 2'd0;
  localparam logic [1:0] ASP_YY = 2'd1;
  localparam logic [1:0] ASP_Y  = 2'd2;
  localparam logic [1:0] ASP_G  = 2'd3;

  localparam logic [7:0] CNT_LAST = 8'(ACK_TIMEOUT - 1);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] speed_lim_q, speed_lim_d;
  logic       brake_q, brake_d;
  logic       alarm_q, alarm_d;
  logic       spad_q, spad_d;
  logic [1:0] cur_aspect_q, cur_aspect_d;

  logic [7:0] restrict_lim;

  // Only the two restrictive aspects reach this lookup.
  assign restrict_lim = (bus.aspect == ASP_Y) ? SPD_Y : SPD_YY;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    speed_lim_d  = speed_lim_q;
    brake_d      = brake_q;
    alarm_d      = alarm_q;
    spad_d       = spad_q;
    cur_aspect_d = cur_aspect_q;

    if (state_q == S_TRIP) begin
      state_d     = S_TRIP;
      speed_lim_d = 8'd0;
      brake_d     = 1'b1;
      alarm_d     = 1'b1;
      spad_d      = 1'b1;
      cnt_d       = 8'd0;
    end else if (bus.aspect_stb) begin
      cur_aspect_d = bus.aspect;
      cnt_d        = 8'd0;
      case (bus.aspect)
        ASP_R: begin
          state_d     = S_TRIP;
          speed_lim_d = 8'd0;
          brake_d     = 1'b1;
          alarm_d     = 1'b1;
          spad_d      = 1'b1;
        end
        ASP_G: begin
          state_d     = S_RUN;
          speed_lim_d = SPD_G;
          brake_d     = 1'b0;
          alarm_d     = 1'b0;
        end
        default: begin
          speed_lim_d = restrict_lim;
          // A late-ack brake is not released by a further restrictive aspect.
          if (state_q != S_BRAKE) begin
            state_d = S_WARN;
            brake_d = 1'b0;
            alarm_d = 1'b1;
          end
        end
      endcase
    end else if (state_q == S_WARN) begin
      if (bus.ack) begin
        state_d = S_RUN;
        alarm_d = 1'b0;
        cnt_d   = 8'd0;
      end else if (cnt_q == CNT_LAST) begin
        state_d = S_BRAKE;
        brake_d = 1'b1;
        cnt_d   = 8'd0;
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
    end else begin
      cnt_d = 8'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      state_q      <= S_HOLD;
      cnt_q        <= 8'd0;
      speed_lim_q  <= 8'd0;
      brake_q      <= 1'b1;
      alarm_q      <= 1'b0;
      spad_q       <= 1'b0;
      cur_aspect_q <= ASP_R;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      speed_lim_q  <= speed_lim_d;
      brake_q      <= brake_d;
      alarm_q      <= alarm_d;
      spad_q       <= spad_d;
      cur_aspect_q <= cur_aspect_d;
    end
  end

  assign bus.speed_lim  = speed_lim_q;
  assign bus.brake      = brake_q;
  assign bus.alarm      = alarm_q;
  assign bus.spad       = spad_q;
  assign bus.cur_aspect = cur_aspect_q;

endmodule

// File: tb/tb_aspect_supervisor.sv
// Directed and random checks of aspect_supervisor against a deadline-based
// behavioural model of the supervision rules.
module tb_aspect_supervisor;
  localparam int TO = 20;

  logic clk = 1'b0;
  logic clr_n;
  always #5 clk = ~clk;

  aspect_supervisor_if ifc ();

  aspect_supervisor #(.ACK_TIMEOUT(TO)) dut (
    .clk  (clk),
    .clr_n(clr_n),
    .bus  (ifc.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Model: mode names, the edge index at which the current warning began, and a limit table.
  localparam int M_HOLD = 0, M_RUN = 1, M_WARN = 2, M_BRAKE = 3, M_TRIP = 4;
  int         m_mode;
  int         m_cyc = 0;
  int         m_warn_start;
  logic [7:0] m_lim;
  logic       m_brake, m_alarm, m_spad;
  logic [1:0] m_cur;
  logic [7:0] lim_tab [4] = '{8'd0, 8'd40, 8'd80, 8'd120};

  task automatic model_edge(input logic c, input logic s, input logic [1:0] a, input logic k);
    m_cyc++;
    if (!c) begin
      m_mode = M_HOLD; m_lim = 8'd0; m_brake = 1'b1; m_alarm = 1'b0; m_spad = 1'b0; m_cur = 2'd0;
    end else if (m_mode == M_TRIP) begin
      // absorbing
    end else if (s) begin
      m_cur = a;
      m_lim = lim_tab[a];
      if (a == 2'd0) begin
        m_mode = M_TRIP; m_brake = 1'b1; m_alarm = 1'b1; m_spad = 1'b1;
      end else if (a == 2'd3) begin
        m_mode = M_RUN; m_brake = 1'b0; m_alarm = 1'b0;
      end else if (m_mode != M_BRAKE) begin
        m_mode = M_WARN; m_brake = 1'b0; m_alarm = 1'b1; m_warn_start = m_cyc;
      end
    end else if (m_mode == M_WARN) begin
      if (k) begin
        m_mode = M_RUN; m_alarm = 1'b0;
      end else if (m_cyc - m_warn_start >= TO) begin
        m_mode = M_BRAKE; m_brake = 1'b1;
      end
    end
  endtask

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_model();
    chk("speed_lim", int'(ifc.speed_lim), int'(m_lim));
    chk("brake", int'(ifc.brake), int'(m_brake));
    chk("alarm", int'(ifc.alarm), int'(m_alarm));
    chk("spad", int'(ifc.spad), int'(m_spad));
    chk("cur_aspect", int'(ifc.cur_aspect), int'(m_cur));
  endtask

  task automatic cycle(input logic c, input logic s, input logic [1:0] a, input logic k);
    clr_n          = c;
    ifc.aspect_stb = s;
    ifc.aspect     = a;
    ifc.ack        = k;
    @(posedge clk);
    model_edge(c, s, a, k);
    @(negedge clk);
    check_model();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 2'd0, 1'b0);
  endtask

  task automatic edges_to_brake(input string tag);
    int n = 0;
    while (ifc.brake !== 1'b1 && n < 40) begin
      idle(1);
      n++;
    end
    chk(tag, n, TO);
  endtask

  initial begin
    ifc.aspect = 2'd0; ifc.aspect_stb = 1'b0; ifc.ack = 1'b0; clr_n = 1'b0;
    @(negedge clk);

    // Reset, then green
    cycle(1'b0, 1'b0, 2'd0, 1'b0);
    cycle(1'b0, 1'b1, 2'd3, 1'b1);
    chk("rst_lim", int'(ifc.speed_lim), 0);
    chk("rst_brake", int'(ifc.brake), 1);
    chk("rst_alarm", int'(ifc.alarm), 0);
    chk("rst_spad", int'(ifc.spad), 0);
    idle(2);
    cycle(1'b1, 1'b1, 2'd3, 1'b0);
    chk("g_lim", int'(ifc.speed_lim), 120);
    chk("g_brake", int'(ifc.brake), 0);
    chk("g_cur", int'(ifc.cur_aspect), 3);

    // Double yellow from RUN, ack five edges later
    cycle(1'b1, 1'b1, 2'd1, 1'b0);
    chk("yy_alarm", int'(ifc.alarm), 1);
    chk("yy_lim", int'(ifc.speed_lim), 40);
    idle(4);
    cycle(1'b1, 1'b0, 2'd0, 1'b1);
    chk("yy_ack_alarm", int'(ifc.alarm), 0);
    idle(25);
    chk("yy_no_brake", int'(ifc.brake), 0);

    // Single yellow, no ack: brake after exactly TO edges
    cycle(1'b1, 1'b1, 2'd2, 1'b0);
    edges_to_brake("y_timeout_edges");
    chk("y_brake_lim", int'(ifc.speed_lim), 80);
    cycle(1'b1, 1'b1, 2'd1, 1'b0);
    chk("brake_yy_brake", int'(ifc.brake), 1);
    chk("brake_yy_lim", int'(ifc.speed_lim), 40);
    cycle(1'b1, 1'b0, 2'd0, 1'b1);
    chk("brake_ack_ignored", int'(ifc.brake), 1);
    cycle(1'b1, 1'b1, 2'd3, 1'b0);
    chk("release_brake", int'(ifc.brake), 0);
    chk("release_lim", int'(ifc.speed_lim), 120);

    // Ack on the final allowed edge wins over the timeout
    cycle(1'b1, 1'b1, 2'd2, 1'b0);
    idle(TO - 1);
    cycle(1'b1, 1'b0, 2'd0, 1'b1);
    chk("ack_at_limit_brake", int'(ifc.brake), 0);
    chk("ack_at_limit_alarm", int'(ifc.alarm), 0);
    idle(25);

    // Strobe plus ack in WARN restarts the wait
    cycle(1'b1, 1'b1, 2'd2, 1'b0);
    idle(5);
    cycle(1'b1, 1'b1, 2'd2, 1'b1);
    chk("stb_ack_alarm", int'(ifc.alarm), 1);
    edges_to_brake("restart_timeout_edges");

    // Red from RUN, then the trip must ignore everything
    cycle(1'b1, 1'b1, 2'd3, 1'b0);
    cycle(1'b1, 1'b1, 2'd0, 1'b0);
    chk("trip_spad", int'(ifc.spad), 1);
    chk("trip_brake", int'(ifc.brake), 1);
    chk("trip_alarm", int'(ifc.alarm), 1);
    chk("trip_lim", int'(ifc.speed_lim), 0);
    cycle(1'b1, 1'b1, 2'd3, 1'b1);
    cycle(1'b1, 1'b0, 2'd0, 1'b1);
    cycle(1'b1, 1'b1, 2'd2, 1'b0);
    chk("trip_held_spad", int'(ifc.spad), 1);
    chk("trip_held_cur", int'(ifc.cur_aspect), 0);
    cycle(1'b0, 1'b0, 2'd0, 1'b0);
    chk("trip_reset_spad", int'(ifc.spad), 0);

    // Reset mid-warning leaves no pending timeout
    cycle(1'b1, 1'b1, 2'd3, 1'b0);
    cycle(1'b1, 1'b1, 2'd2, 1'b0);
    idle(10);
    cycle(1'b0, 1'b0, 2'd0, 1'b0);
    chk("midwarn_rst_alarm", int'(ifc.alarm), 0);
    chk("midwarn_rst_brake", int'(ifc.brake), 1);
    idle(15);
    cycle(1'b1, 1'b1, 2'd3, 1'b0);
    idle(30);
    chk("midwarn_no_residual", int'(ifc.brake), 0);

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      cycle(logic'($urandom_range(0, 99) != 0),
            logic'($urandom_range(0, 5) == 0),
            2'($urandom_range(0, 3)),
            logic'($urandom_range(0, 9) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
